// File: rtl/snake_motion.sv
// Snake body engine: on each accepted frame tick, advances the head one cell in the
// latched direction, checks walls and self-collision, grows on food and shifts the body.
module snake_motion #(
  parameter int GRID_W   = 32,
  parameter int GRID_H   = 24,
  parameter int COORD_W  = 6,
  parameter int MAX_LEN  = 64,
  parameter int LEN_W    = 7,
  parameter int INIT_LEN = 3
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic [31:0]        rstage,
  input  logic               isDrawing,
  input  logic [1:0]         dir_in,
  input  logic               dir_valid,
  input  logic [COORD_W-1:0] food_x,
  input  logic [COORD_W-1:0] food_y,
  input  logic [LEN_W-1:0]   rd_idx,
  output logic [COORD_W-1:0] rd_x,
  output logic [COORD_W-1:0] rd_y,
  output logic [COORD_W-1:0] head_x,
  output logic [COORD_W-1:0] head_y,
  output logic [LEN_W-1:0]   length,
  output logic               busy,
  output logic               ate,
  output logic               update_done,
  output logic               game_over
);
  localparam int IDX_W = $clog2(MAX_LEN);

  typedef enum logic [1:0] {IDLE, MOVE, CHECK, SHIFT} state_t;

  state_t             state, state_nxt;
  logic [COORD_W-1:0] body_x [MAX_LEN];
  logic [COORD_W-1:0] body_y [MAX_LEN];
  logic [1:0]         dir, pend_dir;
  logic               isd_d;
  logic [COORD_W-1:0] nx, ny, cand_x, cand_y;
  logic               grow, wall, hit, accept;
  logic [LEN_W-1:0]   idx, last;

  assign head_x = body_x[0];
  assign head_y = body_y[0];
  assign busy   = (state != IDLE);
  assign accept = isd_d & ~isDrawing & (rstage == 32'd2) & ~game_over & (state == IDLE);
  assign hit    = (body_x[idx[IDX_W-1:0]] == nx) && (body_y[idx[IDX_W-1:0]] == ny);

  // Candidate head for the pending direction, plus the wall test that forbids it.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    cand_x = body_x[0];
    cand_y = body_y[0];
    wall   = 1'b0;
    unique case (pend_dir)
      2'b00: begin wall = (body_y[0] == '0);                      cand_y = body_y[0] - COORD_W'(1); end
      2'b01: begin wall = (body_x[0] == COORD_W'(GRID_W - 1));    cand_x = body_x[0] + COORD_W'(1); end
      2'b10: begin wall = (body_y[0] == COORD_W'(GRID_H - 1));    cand_y = body_y[0] + COORD_W'(1); end
      2'b11: begin wall = (body_x[0] == '0);                      cand_x = body_x[0] - COORD_W'(1); end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (accept) state_nxt = MOVE;
      MOVE:  state_nxt = wall ? IDLE : CHECK;
      CHECK: if (hit) state_nxt = IDLE;
             else if (idx == last) state_nxt = SHIFT;
      SHIFT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees
  // pre-edge values of the others regardless of statement order.
  always_ff @(posedge clock) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      // NOTE: the body store is reset element by element because the starting snake
      // must be visible through the read port right after reset.
      for (int i = 0; i < MAX_LEN; i++) begin
        body_x[i] <= (i < INIT_LEN) ? COORD_W'(GRID_W / 2 - i) : '0;
        body_y[i] <= (i < INIT_LEN) ? COORD_W'(GRID_H / 2)     : '0;
      end
      length      <= LEN_W'(INIT_LEN);
      dir         <= 2'b01;
      pend_dir    <= 2'b01;
      isd_d       <= 1'b0;
      ate         <= 1'b0;
      update_done <= 1'b0;
      game_over   <= 1'b0;
      rd_x        <= '0;
      rd_y        <= '0;
      nx          <= '0;
      ny          <= '0;
      grow        <= 1'b0;
      idx         <= '0;
      last        <= '0;
    end else begin
      isd_d       <= isDrawing;
      ate         <= 1'b0;
      update_done <= 1'b0;

      // A request that exactly reverses the committed heading is ignored.
      if (dir_valid && (dir_in != (dir ^ 2'b10))) pend_dir <= dir_in;

      unique case (state)
        MOVE: begin
          dir <= pend_dir;
          if (wall) begin
            game_over   <= 1'b1;
            update_done <= 1'b1;
          end else begin
            nx   <= cand_x;
            ny   <= cand_y;
            idx  <= LEN_W'(1);
            grow <= (cand_x == food_x) && (cand_y == food_y);
            // The tail cell vacates this move unless the snake grows.
            last <= ((cand_x == food_x) && (cand_y == food_y)) ? length - LEN_W'(1)
                                                               : length - LEN_W'(2);
          end
        end
        CHECK: begin
          if (hit) begin
            game_over   <= 1'b1;
            update_done <= 1'b1;
          end else begin
            idx <= idx + LEN_W'(1);
          end
        end
        SHIFT: begin
          for (int i = 1; i < MAX_LEN; i++) begin
            body_x[i] <= body_x[i-1];
            body_y[i] <= body_y[i-1];
          end
          body_x[0]   <= nx;
          body_y[0]   <= ny;
          update_done <= 1'b1;
          if (grow) begin
            ate <= 1'b1;
            if (length != LEN_W'(MAX_LEN)) length <= length + LEN_W'(1);
          end
        end
        default: ;
      endcase

      rd_x <= (rd_idx < LEN_W'(MAX_LEN)) ? body_x[rd_idx[IDX_W-1:0]] : '0;
      rd_y <= (rd_idx < LEN_W'(MAX_LEN)) ? body_y[rd_idx[IDX_W-1:0]] : '0;
    end
  end
endmodule

// File: tb/tb_snake_motion.sv
// Bench for snake_motion: directed scenarios then random play, compared against a
// queue-based model of the snake built from the movement rules.
module tb_snake_motion;
  localparam int MAX_LEN = 64;
  localparam int BUDGET  = 80;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] rstage = 32'd0;
  logic        isDrawing = 1'b0;
  logic [1:0]  dir_in = 2'b00;
  logic        dir_valid = 1'b0;
  logic [5:0]  food_x = 6'd0, food_y = 6'd0;
  logic [6:0]  rd_idx = 7'd0;
  logic [5:0]  rd_x, rd_y, head_x, head_y;
  logic [6:0]  length;
  logic        busy, ate, update_done, game_over;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: full body storage as coordinate queues, head at the front.
  int mx[$], my[$];
  int mlen, mdir, mpend;
  bit mgo;

  snake_motion dut (
    .clock(clock), .resetn(resetn), .rstage(rstage), .isDrawing(isDrawing),
    .dir_in(dir_in), .dir_valid(dir_valid), .food_x(food_x), .food_y(food_y),
    .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y), .head_x(head_x), .head_y(head_y),
    .length(length), .busy(busy), .ate(ate), .update_done(update_done),
    .game_over(game_over)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int step_x(input int d);
    return (d == 1) ? 1 : (d == 3) ? -1 : 0;
  endfunction

  function automatic int step_y(input int d);
    return (d == 2) ? 1 : (d == 0) ? -1 : 0;
  endfunction

  task automatic model_reset();
    mx.delete(); my.delete();
    for (int i = 0; i < MAX_LEN; i++) begin
      mx.push_back(i < 3 ? 16 - i : 0);
      my.push_back(i < 3 ? 12 : 0);
    end
    mlen = 3; mdir = 1; mpend = 1; mgo = 0;
  endtask

  // Applies one accepted move; returns the number of clock edges from tick to update_done.
  task automatic model_move(output int lat, output bit grew);
    int nxv, nyv, last;
    bit g;
    grew = 0;
    mdir = mpend;
    nxv = mx[0] + step_x(mdir);
    nyv = my[0] + step_y(mdir);
    if (nxv < 0 || nxv > 31 || nyv < 0 || nyv > 23) begin
      mgo = 1; lat = 2; return;
    end
    g = (nxv == int'(food_x)) && (nyv == int'(food_y));
    last = g ? mlen - 1 : mlen - 2;
    for (int i = 1; i <= last; i++) begin
      if (mx[i] == nxv && my[i] == nyv) begin
        mgo = 1; lat = 2 + i; return;
      end
    end
    mx.push_front(nxv); my.push_front(nyv);
    void'(mx.pop_back()); void'(my.pop_back());
    if (g && mlen < MAX_LEN) mlen++;
    grew = g;
    lat = 3 + last;
  endtask

  task automatic do_reset();
    resetn = 1'b0; isDrawing = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    model_reset();
  endtask

  task automatic req_dir(input int d);
    dir_in = 2'(d); dir_valid = 1'b1;
    @(negedge clock);
    dir_valid = 1'b0;
    if (d != (mdir ^ 2)) mpend = d;
  endtask

  task automatic check_rd(input string tag, input int i);
    rd_idx = 7'(i);
    @(negedge clock);
    check({tag, "_rdx"}, int'(rd_x), i < MAX_LEN ? mx[i] : 0);
    check({tag, "_rdy"}, int'(rd_y), i < MAX_LEN ? my[i] : 0);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_hx"},   int'(head_x),    mx[0]);
    check({tag, "_hy"},   int'(head_y),    my[0]);
    check({tag, "_len"},  int'(length),    mlen);
    check({tag, "_go"},   int'(game_over), int'(mgo));
    check({tag, "_busy"}, int'(busy),      0);
  endtask

  // One isDrawing 1->0 pulse; optionally a second pulse that lands while busy.
  task automatic run_tick(input string tag, input bit inject);
    int exp_lat, c, extra;
    bit exp_grow, accepted, seen, ate_seen;
    exp_lat = 0; exp_grow = 0;
    accepted = (rstage == 32'd2) && !mgo;
    if (accepted) model_move(exp_lat, exp_grow);
    isDrawing = 1'b1;
    @(negedge clock);
    isDrawing = 1'b0;
    seen = 0; ate_seen = 0; c = 0;
    while (!seen && c < BUDGET) begin
      @(negedge clock);
      c++;
      if (inject && c == 1) isDrawing = 1'b1;
      if (inject && c == 2) isDrawing = 1'b0;
      if (update_done) begin seen = 1; ate_seen = ate; end
    end
    check({tag, "_done"}, int'(seen), int'(accepted));
    if (accepted) begin
      check({tag, "_lat"}, c, exp_lat);
      check({tag, "_ate"}, int'(ate_seen), int'(exp_grow));
    end
    if (inject) begin
      extra = 0;
      repeat (15) begin
        @(negedge clock);
        if (update_done) extra++;
      end
      check({tag, "_busy_drop"}, extra, 0);
    end
    check_state(tag);
  endtask

  initial begin
    int nxv, nyv;
    model_reset();

    // Reset state and read port
    do_reset();
    check("rst_hx", int'(head_x), 16);
    check("rst_hy", int'(head_y), 12);
    check("rst_len", int'(length), 3);
    check("rst_go", int'(game_over), 0);
    check_state("rst");
    check_rd("rst2", 2);
    check("rst_rd2_x_const", int'(rd_x), 14);
    check_rd("rst_oob", 100);

    // Plain move right
    rstage = 32'd2; food_x = 6'd0; food_y = 6'd0;
    run_tick("mv1", 1'b0);
    check("mv1_hx_const", int'(head_x), 17);

    // Reverse request ignored, then turn up
    req_dir(3);
    run_tick("rev", 1'b0);
    check("rev_hx_const", int'(head_x), 18);
    req_dir(0);
    run_tick("up", 1'b0);
    check("up_hy_const", int'(head_y), 11);

    // Two food pickups
    req_dir(1);
    food_x = 6'd19; food_y = 6'd11;
    run_tick("eat1", 1'b0);
    check("eat1_len_const", int'(length), 4);
    check_rd("eat1_tail", 3);
    food_x = 6'd20;
    run_tick("eat2", 1'b0);
    food_x = 6'd0; food_y = 6'd0;

    // Curl into own body; a tick during the first move must be dropped
    req_dir(0);
    run_tick("curl_up", 1'b1);
    req_dir(3);
    run_tick("curl_left", 1'b0);
    req_dir(2);
    run_tick("curl_down", 1'b0);
    check("self_go_const", int'(game_over), 1);
    check("self_hx_const", int'(head_x), 19);
    run_tick("after_go", 1'b0);

    // Reset in the middle of an update discards the move
    do_reset();
    rstage = 32'd2;
    isDrawing = 1'b1; @(negedge clock);
    isDrawing = 1'b0; @(negedge clock);
    resetn = 1'b0; @(negedge clock);
    resetn = 1'b1;
    model_reset();
    check("midrst_busy", int'(busy), 0);
    check_state("midrst");

    // Stage gating, then run into the right wall
    rstage = 32'd1;
    run_tick("stage1", 1'b0);
    rstage = 32'd2;
    for (int i = 0; i < 15; i++) run_tick("to_wall", 1'b0);
    check("wall_pre_hx_const", int'(head_x), 31);
    run_tick("wall", 1'b0);
    check("wall_go_const", int'(game_over), 1);
    run_tick("wall_after", 1'b0);

    // Random play
    do_reset();
    for (int it = 0; it < 120; it++) begin
      if ($urandom_range(0, 9) < 4) req_dir(int'($urandom_range(0, 3)));
      nxv = mx[0] + step_x(mpend);
      nyv = my[0] + step_y(mpend);
      if ($urandom_range(0, 2) == 0 && nxv >= 0 && nxv < 32 && nyv >= 0 && nyv < 24) begin
        food_x = 6'(nxv); food_y = 6'(nyv);
      end else begin
        food_x = 6'($urandom_range(0, 31)); food_y = 6'($urandom_range(0, 23));
      end
      rstage = ($urandom_range(0, 7) == 0) ? 32'd1 : 32'd2;
      run_tick("rnd", 1'b0);
      if ($urandom_range(0, 3) == 0) check_rd("rnd", int'($urandom_range(0, 70)));
      if (mgo) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
